uart_tx_serializer: RTL

Transmit-side stage that sits directly downstream of the transmit FWFT FIFO. It pops one byte at a time through the FIFO's look-ahead interface and serializes each byte onto the TXD line: start bit, data LSB first, optional parity, then one or two stop bits. Bit timing comes from an internal programmable baud divider. Bytes flagged with a FIFO parity (storage) error are popped and dropped, never transmitted.

---
 rtl/uart_tx_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer fed from an FWFT FIFO: start, DW data bits LSB first, optional parity, 1/2 stop bits.
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DW    = 8,
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_tx_en,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_stop2,
  input  logic             i_parity_en,
  input  logic             i_parity_odd,
  input  logic             i_fifo_valid,
  input  logic [DW-1:0]    i_fifo_data,
  input  logic             i_fifo_parity_error,
  output logic             o_fifo_rd_req,
  output logic             o_txd,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_drop
);

  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] div_load;
  logic [CNT_W-1:0] bit_cnt;
  logic [DW-1:0]    shift;
  logic             stop2_q;
  logic             stop_idx;
  logic             txd_q;
  logic             bit_end;
  logic             last_stop;
  logic             pop;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity;
  assign unused_parity = i_parity_en ^ i_parity_odd;
`endif

  assign div_load  = (i_baud_div == '0) ? '0 : i_baud_div - DIV_W'(1);
  assign bit_end   = (timer == '0);
  assign last_stop = (state == S_STOP) && bit_end && (stop_idx == stop2_q);

  // Gated by i_nrst so the pop strobe is held low while reset is asserted.
  assign pop = i_nrst && i_tx_en && i_fifo_valid && ((state == S_IDLE) || last_stop);

  assign o_fifo_rd_req = pop;
  assign o_drop        = pop && i_fifo_parity_error;
  assign o_frame_done  = last_stop;
  assign o_busy        = (state != S_IDLE);
  assign o_txd         = txd_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE && !bit_end)
        timer <= timer - DIV_W'(1);

      case (state)
        S_IDLE: ;
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            txd_q   <= shift[0];
            timer   <= div_load;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer <= div_load;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= S_PARITY;
                txd_q <= par_bit_q;
              end else begin
                state    <= S_STOP;
                txd_q    <= 1'b1;
                stop_idx <= 1'b0;
              end
`else
              state    <= S_STOP;
              txd_q    <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              shift   <= shift >> 1;
              txd_q   <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            txd_q    <= 1'b1;
            stop_idx <= 1'b0;
            timer    <= div_load;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
              timer    <= div_load;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A pop overrides the STOP->IDLE exit, giving zero-gap back-to-back frames.
      if (pop) begin
        if (i_fifo_parity_error) begin
          state <= S_IDLE;
          txd_q <= 1'b1;
        end else begin
          state   <= S_START;
          txd_q   <= 1'b0;
          timer   <= div_load;
          shift   <= i_fifo_data;
          stop2_q <= i_stop2;
`ifdef UART_TX_PARITY_EN
          par_en_q  <= i_parity_en;
          par_bit_q <= (^i_fifo_data) ^ i_parity_odd;
`endif
        end
      end
    end
  end

endmodule
